// File: rtl/multdiv_iter_if.sv
// Handshake and data bundle between the execute stage and the iterative multiply/divide unit.
interface multdiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             ctrl_signed;
  logic             ctrl_abort;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_result_alt;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, ctrl_signed, ctrl_abort, data_operandA, data_operandB,
    input  data_result, data_result_alt, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, ctrl_signed, ctrl_abort, data_operandA, data_operandB,
    output data_result, data_result_alt, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiply/divide: shift-add multiply, restoring divide, on operand magnitudes
// with sign fix-up and exception detection in a final FIX cycle.
module multdiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           reset_n,
  multdiv_iter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             is_mult_q, is_mult_d, sgn_q, sgn_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0] res_q, res_d, alt_q, alt_d;
  logic             exc_q, exc_d;

  // Operand magnitudes for the start cycle
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = bus.ctrl_signed & bus.data_operandA[WIDTH-1];
  assign b_neg = bus.ctrl_signed & bus.data_operandB[WIDTH-1];
  assign a_mag = a_neg ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = b_neg ? -bus.data_operandB : bus.data_operandB;

  // One multiply step: {hi,lo} holds accumulator and remaining multiplier bits
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

  // One restoring divide step: hi is the partial remainder, lo shifts dividend out, quotient in
  logic [WIDTH:0] div_tmp, div_diff;
  logic           div_ge;
  assign div_tmp  = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, b_q};
  assign div_ge   = div_tmp >= {1'b0, b_q};

  // Sign correction and exception rules for the FIX cycle
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               neg_res, rem_neg, mul_exc, div_zero;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign neg_res  = sgn_q & (sign_a_q ^ sign_b_q);
  assign rem_neg  = sgn_q & sign_a_q;
  assign prod     = {hi_q, lo_q};
  assign prod_s   = neg_res ? -prod : prod;
  assign mul_exc  = sgn_q ? !((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]))
                          : (|prod_s[2*WIDTH-1:WIDTH]);
  assign q_fix    = neg_res ? -lo_q : lo_q;
  assign r_fix    = rem_neg ? -hi_q : hi_q;
  assign div_zero = (b_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    is_mult_d = is_mult_q;
    sgn_d     = sgn_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    res_d     = res_q;
    alt_d     = alt_q;
    exc_d     = exc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ctrl_MULT | bus.ctrl_DIV) begin
          is_mult_d = bus.ctrl_MULT;
          sgn_d     = bus.ctrl_signed;
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          hi_d      = '0;
          lo_d      = a_mag;
          b_d       = b_mag;
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (bus.ctrl_abort) begin
          state_d = StIdle;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_mult_q) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end
        end
      end
      StFix: begin
        if (bus.ctrl_abort) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          if (is_mult_q) begin
            res_d = prod_s[WIDTH-1:0];
            alt_d = prod_s[2*WIDTH-1:WIDTH];
            exc_d = mul_exc;
          end else if (div_zero) begin
            // Partial remainder has accumulated the whole dividend magnitude by now
            res_d = sgn_q ? '0 : '1;
            alt_d = r_fix;
            exc_d = 1'b1;
          end else begin
            res_d = q_fix;
            alt_d = r_fix;
            // A positive signed quotient of magnitude 2^(W-1) only arises from MIN / -1
            exc_d = sgn_q & ~neg_res & lo_q[WIDTH-1];
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      is_mult_q <= 1'b0;
      sgn_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      res_q     <= '0;
      alt_q     <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      is_mult_q <= is_mult_d;
      sgn_q     <= sgn_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      res_q     <= res_d;
      alt_q     <= alt_d;
      exc_q     <= exc_d;
    end
  end

  assign bus.data_result     = res_q;
  assign bus.data_result_alt = alt_q;
  assign bus.data_exception  = exc_q;
  assign bus.data_resultRDY  = (state_q == StDone);
  assign bus.busy            = (state_q == StRun) || (state_q == StFix);
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed checks of multdiv_iter at WIDTH=32 plus a WIDTH=8 random run against an integer model.
module tb_multdiv_iter;
  logic clock;
  logic reset_n;

  multdiv_iter_if #(.WIDTH(32)) b32 ();
  multdiv_iter_if #(.WIDTH(8))  b8 ();

  multdiv_iter #(.WIDTH(32)) u_dut32 (.clock(clock), .reset_n(reset_n), .bus(b32));
  multdiv_iter #(.WIDTH(8))  u_dut8  (.clock(clock), .reset_n(reset_n), .bus(b8));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic start32(input logic mult, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b);
    @(negedge clock);
    while (b32.data_resultRDY) @(negedge clock);
    b32.ctrl_MULT     = mult;
    b32.ctrl_DIV      = !mult;
    b32.ctrl_signed   = sgn;
    b32.data_operandA = a;
    b32.data_operandB = b;
    @(posedge clock);
    #1;
    b32.ctrl_MULT     = 1'b0;
    b32.ctrl_DIV      = 1'b0;
    b32.ctrl_signed   = 1'b0;
    b32.data_operandA = 32'hDEADBEEF;
    b32.data_operandB = 32'h12345678;
  endtask

  // Returns the edge count at which RDY was seen, or 0 if it never rose within the bound
  task automatic wait32(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (b32.data_resultRDY) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic op32(input string tag, input logic mult, input logic sgn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                      input logic [31:0] ealt, input logic eexc);
    int n;
    start32(mult, sgn, a, b);
    wait32(n);
    check({tag, " lat"}, n, 34);
    check({tag, " res"}, b32.data_result, er);
    check({tag, " alt"}, b32.data_result_alt, ealt);
    check({tag, " exc"}, b32.data_exception, eexc);
  endtask

  task automatic start8(input logic mult, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b);
    @(negedge clock);
    while (b8.data_resultRDY) @(negedge clock);
    b8.ctrl_MULT     = mult;
    b8.ctrl_DIV      = !mult;
    b8.ctrl_signed   = sgn;
    b8.data_operandA = a;
    b8.data_operandB = b;
    @(posedge clock);
    #1;
    b8.ctrl_MULT = 1'b0;
    b8.ctrl_DIV  = 1'b0;
  endtask

  task automatic wait8(output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clock);
      #1;
      if (b8.data_resultRDY) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic void model8(input logic mult, input logic sgn, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic [7:0] alt, output logic e);
    int sa, sb, p, q, m;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    if (mult) begin
      p   = sa * sb;
      r   = p[7:0];
      alt = p[15:8];
      e   = sgn ? (p < -128 || p > 127) : (p > 255);
    end else if (b == 8'h00) begin
      r   = sgn ? 8'h00 : 8'hFF;
      alt = a;
      e   = 1'b1;
    end else if (sgn && sa == -128 && sb == -1) begin
      r   = 8'h80;
      alt = 8'h00;
      e   = 1'b1;
    end else begin
      q   = sa / sb;
      m   = sa % sb;
      r   = q[7:0];
      alt = m[7:0];
      e   = 1'b0;
    end
  endfunction

  initial begin
    int n;
    logic [7:0] ra, rb, er, ealt;
    logic ee, rm, rs;

    reset_n = 1'b0;
    {b32.ctrl_MULT, b32.ctrl_DIV, b32.ctrl_signed, b32.ctrl_abort} = 4'b0;
    b32.data_operandA = '0;
    b32.data_operandB = '0;
    {b8.ctrl_MULT, b8.ctrl_DIV, b8.ctrl_signed, b8.ctrl_abort} = 4'b0;
    b8.data_operandA = '0;
    b8.data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst res", b32.data_result, 32'h0);
    check("rst alt", b32.data_result_alt, 32'h0);
    check("rst exc", b32.data_exception, 1'b0);
    check("rst rdy", b32.data_resultRDY, 1'b0);
    check("rst busy", b32.busy, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    op32("smul -7*6", 1, 1, -32'sd7, 32'd6, -32'sd42, 32'hFFFFFFFF, 0);
    op32("smul ovf", 1, 1, 32'h40000000, 32'd4, 32'h0, 32'h1, 1);
    op32("umul ovf", 1, 0, 32'h40000000, 32'd4, 32'h0, 32'h1, 1);
    op32("sdiv -7/2", 0, 1, -32'sd7, 32'd2, -32'sd3, -32'sd1, 0);
    op32("udiv 100/7", 0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    op32("udiv by0", 0, 0, 32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1);
    op32("sdiv by0", 0, 1, -32'sd55, 32'd0, 32'h0, -32'sd55, 1);
    op32("sdiv min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1);

    // Abort on the 10th RUN edge: no RDY and results stay from the previous op
    start32(0, 0, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    @(negedge clock);
    check("abort busy before", b32.busy, 1'b1);
    b32.ctrl_abort = 1'b1;
    @(posedge clock);
    #1;
    b32.ctrl_abort = 1'b0;
    check("abort busy after", b32.busy, 1'b0);
    wait32(n);
    check("abort no rdy", n, 0);
    check("abort res held", b32.data_result, 32'h80000000);
    check("abort exc held", b32.data_exception, 1'b1);

    // Start pulse with other operands during RUN must be ignored
    start32(1, 0, 32'd3, 32'd5);
    repeat (4) @(posedge clock);
    @(negedge clock);
    b32.ctrl_DIV      = 1'b1;
    b32.data_operandA = 32'd100;
    b32.data_operandB = 32'd7;
    @(posedge clock);
    #1;
    b32.ctrl_DIV = 1'b0;
    wait32(n);
    check("ign lat", n + 5, 34);
    check("ign res", b32.data_result, 32'd15);
    check("ign alt", b32.data_result_alt, 32'd0);
    check("ign exc", b32.data_exception, 1'b0);

    // Back-to-back: second start issued in the IDLE cycle right after DONE
    op32("b2b first", 1, 0, 32'd6, 32'd7, 32'd42, 32'd0, 0);
    start32(1, 1, -32'sd3, -32'sd5);
    check("b2b accepted", b32.busy, 1'b1);
    check("b2b res held", b32.data_result, 32'd42);
    wait32(n);
    check("b2b second lat", n, 34);
    check("b2b second res", b32.data_result, 32'd15);
    check("b2b second alt", b32.data_result_alt, 32'd0);
    check("b2b second exc", b32.data_exception, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom);
      case ($urandom_range(0, 15))
        0:       rb = 8'h00;
        1:       rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      model8(rm, rs, ra, rb, er, ealt, ee);
      start8(rm, rs, ra, rb);
      wait8(n);
      check($sformatf("w8 #%0d lat", i), n, 10);
      check($sformatf("w8 #%0d m%0d s%0d %h,%h res", i, rm, rs, ra, rb), b8.data_result, er);
      check($sformatf("w8 #%0d m%0d s%0d %h,%h alt", i, rm, rs, ra, rb),
            b8.data_result_alt, ealt);
      check($sformatf("w8 #%0d m%0d s%0d %h,%h exc", i, rm, rs, ra, rb),
            b8.data_exception, ee);
    end

    // Asynchronous reset mid-RUN clears outputs at once and loses the operation
    start32(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst res", b32.data_result, 32'h0);
    check("arst alt", b32.data_result_alt, 32'h0);
    check("arst exc", b32.data_exception, 1'b0);
    check("arst busy", b32.busy, 1'b0);
    check("arst rdy", b32.data_resultRDY, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    wait32(n);
    check("arst no rdy", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
